// File: rtl/fifo_rd_drain_ctrl.sv
// fifo_rd_drain_ctrl
// Read-side master for the synchronous FIFO. It issues read strobes, captures
// the returned word one cycle later and presents it downstream as a
// valid/ready stream through a small circular skid buffer.
// Optional feature macro: FIFO_RD_BURST_EN. When it is defined, draining starts
// only on half_full_i or a flush_i pulse, and it runs until the FIFO is empty.
module fifo_rd_drain_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_ENTRIES = 1024,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic                              fifo_empty_i,
    input  logic                              half_full_i,
    input  logic                              flush_i,
    input  logic [DATA_WIDTH-1:0]             data_out_i,
    output logic                              rd_o,
    output logic                              oe_o,
    output logic                              m_valid_o,
    input  logic                              m_ready_i,
    output logic [DATA_WIDTH-1:0]             m_data_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_ENTRIES):0]     rd_cnt_o
);

    localparam int PTR_W   = $clog2(BUF_DEPTH);
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam int RDCNT_W = $clog2(FIFO_ENTRIES) + 1;
    localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_L  = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      buf_cnt;
    logic                  start_cond;
    logic                  credit_ok;
    logic                  capture;
    logic                  pop;

    // Pointer advance for a circular buffer whose depth need not be a power of two
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == LAST_L) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

`ifdef FIFO_RD_BURST_EN
    logic flush_pend;

    assign start_cond = half_full_i | flush_i | flush_pend;

    // Remember a flush request until the controller actually starts draining
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_pend <= 1'b0;
        end else if ((state == IDLE) && start_cond) begin
            flush_pend <= 1'b0;
        end else if (flush_i) begin
            flush_pend <= 1'b1;
        end
    end
`else
    logic unused_burst_inputs;

    assign unused_burst_inputs = half_full_i ^ flush_i;
    assign start_cond          = ~fifo_empty_i;
`endif

    // A read is issued only when a buffer slot is guaranteed for the returned word
    assign credit_ok = (({1'b0, buf_cnt} + {{CNT_W{1'b0}}, inflight}) < DEPTH_L);
    assign rd_o      = enable_i & (state == DRAIN) & ~fifo_empty_i & credit_ok;

    assign oe_o      = inflight;
    assign capture   = inflight;
    assign m_valid_o = (buf_cnt != '0);
    assign m_data_o  = buf_mem[head];
    assign pop       = m_valid_o & m_ready_i;
    assign busy_o    = (state != IDLE) | inflight | (buf_cnt != '0);

    // Two-state drain controller; it leaves DRAIN only once nothing is left in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cond) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty_i && !inflight && !rd_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The word requested this cycle comes back from the FIFO next cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_o;
        end
    end

    // Skid buffer storage; the contents are don't-care while the count is zero
    always_ff @(posedge clk_i) begin
        if (capture) begin
            buf_mem[tail] <= data_out_i;
        end
    end

    // Skid buffer bookkeeping; a capture and a pop in the same cycle cancel out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head    <= '0;
            tail    <= '0;
            buf_cnt <= '0;
        end else begin
            if (capture) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            if (capture && !pop) begin
                buf_cnt <= buf_cnt + CNT_W'(1);
            end else if (pop && !capture) begin
                buf_cnt <= buf_cnt - CNT_W'(1);
            end
        end
    end

    // Count words handed downstream; it wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_o <= '0;
        end else if (pop) begin
            rd_cnt_o <= rd_cnt_o + RDCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain_ctrl.sv
// tb_fifo_rd_drain_ctrl
// Self-checking bench: a behavioural FIFO model feeds the controller. Every
// written word is queued as expected output, and a monitor pops and compares
// it whenever the controller hands a word downstream.
// Define FIFO_RD_BURST_EN to run the burst-mode scenario instead of the
// default-mode scenarios.
module tb_fifo_rd_drain_ctrl;

    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          fifo_empty_i;
    logic          half_full_i;
    logic          flush_i;
    logic [DW-1:0] data_out_i;
    logic          rd_o;
    logic          oe_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_data_o;
    logic          busy_o;
    logic [10:0]   rd_cnt_o;

    logic          wr_en;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];

    int errors     = 0;
    int checks     = 0;
    int rd_pulses  = 0;
    int delivered  = 0;
    int underflows = 0;

    fifo_rd_drain_ctrl #(
        .DATA_WIDTH  (16),
        .FIFO_ENTRIES(1024),
        .BUF_DEPTH   (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .fifo_empty_i(fifo_empty_i),
        .half_full_i (half_full_i),
        .flush_i     (flush_i),
        .data_out_i  (data_out_i),
        .rd_o        (rd_o),
        .oe_o        (oe_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .busy_o      (busy_o),
        .rd_cnt_o    (rd_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural synchronous FIFO: registered flags, read data the cycle after rd_o
    always @(posedge clk_i) begin
        logic [DW-1:0] rdata;
        if (rd_o) begin
            rd_pulses++;
            if (fifo_empty_i || fifo_q.size() == 0) begin
                underflows++;
            end else begin
                rdata = fifo_q.pop_front();
                data_out_i <= rdata;
            end
        end
        if (wr_en && fifo_q.size() < 1024) begin
            fifo_q.push_back(wr_data);
        end
        fifo_empty_i <= (fifo_q.size() == 0);
        half_full_i  <= (fifo_q.size() >= 512);
    end

    // Scoreboard monitor: every downstream handshake must match the next expected word
    always @(negedge clk_i) begin
        logic [DW-1:0] exp_w;
        if (!rst_i && m_valid_o && m_ready_i) begin
            checks++;
            delivered++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL stream_extra: got %04h, expected no word", m_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (m_data_o !== exp_w) begin
                    errors++;
                    $display("[TB] FAIL stream_data: got %04h, expected %04h", m_data_o, exp_w);
                end
            end
        end
    end

    // Hard stop so that a stuck design can never hang the run
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Write n consecutive words into the FIFO model, one per cycle
    task automatic applyStimulus(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + DW'(i);
            exp_q.push_back(wr_data);
            @(posedge clk_i);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Wait until everything written has been delivered and the controller is idle
    task automatic waitDrain(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy_o) begin
                break;
            end
        end
        if (k == budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d words pending, expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        int base_rd;
        int base_dl;
        int saved_level;
        int k;

        rst_i     = 1'b1;
        enable_i  = 1'b0;
        flush_i   = 1'b0;
        m_ready_i = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        fifo_empty_i = 1'b1;
        half_full_i  = 1'b0;
        data_out_i   = '0;

        // Reset behaviour
        #149;
        checkOutput("rst_rd",    rd_o,      0);
        checkOutput("rst_oe",    oe_o,      0);
        checkOutput("rst_valid", m_valid_o, 0);
        checkOutput("rst_busy",  busy_o,    0);
        checkOutput("rst_cnt",   rd_cnt_o,  0);
        #1;
        rst_i = 1'b0;
        enable_i  = 1'b1;
        m_ready_i = 1'b1;
        waitCycles(5);
        checkOutput("idle_rd",    rd_o,      0);
        checkOutput("idle_valid", m_valid_o, 0);
        checkOutput("idle_busy",  busy_o,    0);
        checkOutput("idle_cnt",   rd_cnt_o,  0);

`ifndef FIFO_RD_BURST_EN
        // Single word with exact latency
        applyStimulus(16'hA5A5, 1);
        for (k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (rd_o) break;
        end
        checkOutput("t2_rd_seen", 32'(k < 10), 1);
        @(negedge clk_i);
        checkOutput("t2_oe",    oe_o, 1);
        checkOutput("t2_rd_lo", rd_o, 0);
        @(negedge clk_i);
        checkOutput("t2_valid", m_valid_o, 1);
        checkOutput("t2_data",  m_data_o,  16'hA5A5);
        @(negedge clk_i);
        checkOutput("t2_busy",  busy_o,   0);
        checkOutput("t2_cnt",   rd_cnt_o, 1);
        @(posedge clk_i);
        #1;

        // Backpressure: only two reads may be outstanding with ready low
        m_ready_i = 1'b0;
        base_rd = rd_pulses;
        base_dl = delivered;
        applyStimulus(16'h0001, 8);
        waitCycles(10);
        checkOutput("t3_reads",  rd_pulses - base_rd, 2);
        checkOutput("t3_rd_lo",  rd_o,      0);
        checkOutput("t3_valid",  m_valid_o, 1);
        checkOutput("t3_head",   m_data_o,  16'h0001);
        m_ready_i = 1'b1;
        waitDrain("t3", 100);
        checkOutput("t3_words", delivered - base_dl, 8);
        checkOutput("t3_cnt",   rd_cnt_o, 9);

        // Full FIFO drain
        enable_i = 1'b0;
        applyStimulus(16'h0000, 1024);
        enable_i = 1'b1;
        waitDrain("t4", 3000);
        checkOutput("t4_cnt", rd_cnt_o, 1033);

        // Enable drop after five reads, then reset with two words buffered
        enable_i = 1'b0;
        applyStimulus(16'h0100, 10);
        base_rd = rd_pulses;
        base_dl = delivered;
        enable_i = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(posedge clk_i);
            #1;
            if (rd_pulses - base_rd >= 5) break;
        end
        enable_i = 1'b0;
        waitCycles(10);
        checkOutput("t5_reads", rd_pulses - base_rd, 5);
        checkOutput("t5_words", delivered - base_dl, 5);
        checkOutput("t5_busy",  busy_o, 1);
        m_ready_i = 1'b0;
        enable_i  = 1'b1;
        waitCycles(10);
        checkOutput("t5_reads2", rd_pulses - base_rd, 7);
        checkOutput("t5_valid",  m_valid_o, 1);
        checkOutput("t5_head",   m_data_o,  16'h0105);
        saved_level = fifo_q.size();
        checkOutput("t5_level", saved_level, 3);
        rst_i = 1'b1;
        #2;
        checkOutput("t5_rst_valid", m_valid_o, 0);
        checkOutput("t5_rst_rd",    rd_o,      0);
        checkOutput("t5_rst_cnt",   rd_cnt_o,  0);
        @(posedge clk_i);
        #1;
        checkOutput("t5_level_kept", fifo_q.size(), saved_level);
        exp_q = fifo_q;
        rst_i = 1'b0;
        m_ready_i = 1'b1;
        waitDrain("t5", 100);
        checkOutput("t5_cnt", rd_cnt_o, 3);
`else
        // Burst mode: nothing drains below half full
        base_rd = rd_pulses;
        base_dl = delivered;
        applyStimulus(16'h1000, 511);
        waitCycles(20);
        checkOutput("t6_no_reads", rd_pulses - base_rd, 0);
        checkOutput("t6_idle",     busy_o, 0);
        applyStimulus(16'h11FF, 1);
        waitDrain("t6", 2000);
        checkOutput("t6_words", delivered - base_dl, 512);
        checkOutput("t6_cnt",   rd_cnt_o, 512);
        base_rd = rd_pulses;
        applyStimulus(16'h2000, 3);
        waitCycles(10);
        checkOutput("t6_wait", rd_pulses - base_rd, 0);
        flush_i = 1'b1;
        waitCycles(1);
        flush_i = 1'b0;
        waitDrain("t6_flush", 100);
        checkOutput("t6_flush_reads", rd_pulses - base_rd, 3);
        checkOutput("t6_flush_cnt",   rd_cnt_o, 515);
        checkOutput("t6_flush_idle",  busy_o, 0);
`endif

        waitCycles(3);
        checkOutput("no_underflow", underflows, 0);
        checkOutput("all_words",    exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
